lane_span_scheduler: RTL and testbench

// - Parametrised successor to the per-row erase/draw sequencers. Snapshots old and new tile-lane codes for every row
//   on one start pulse, then walks all rows in order: erase the old span (white), then draw the new span (black).
// - Emits one pixel per cycle on a single plot port that feeds the VGA adapter. Raises done when the frame update is complete.

---
 rtl/tiles_pkg.sv | 21 ++
 rtl/lane_span_scheduler_if.sv | 24 ++
 rtl/lane_span_scheduler_span_walker.sv | 57 +++++
 rtl/lane_span_scheduler.sv | 143 ++++++++++++++
 tb/tb_lane_span_scheduler.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/tiles_pkg.sv
// Shared tile-lane geometry, colours and scheduler state codes.
package tiles_pkg;
    localparam int NUM_ROWS  = 6;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 20;
    localparam int LANE_X0   = 120;
    localparam int ROW_H     = 40;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int OFS_W     = 6;
    localparam int CODE_W    = 3;

    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [CODE_W-1:0] LANE_NONE = '0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ERASE = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/lane_span_scheduler_if.sv
// Request/plot bundle between a lane-code producer and the span scheduler.
interface lane_span_scheduler_if #(
    parameter int NUM_ROWS = tiles_pkg::NUM_ROWS,
    parameter int CODE_W   = tiles_pkg::CODE_W,
    parameter int OFS_W    = tiles_pkg::OFS_W,
    parameter int X_W      = tiles_pkg::X_W,
    parameter int Y_W      = tiles_pkg::Y_W
);
    logic                       start;
    logic [OFS_W-1:0]           offset;
    logic [NUM_ROWS*CODE_W-1:0] old_lane;
    logic [NUM_ROWS*CODE_W-1:0] new_lane;
    logic                       plot;
    logic [X_W-1:0]             x;
    logic [Y_W-1:0]             y;
    logic [2:0]                 colour;
    logic                       busy;
    logic                       done;

    modport master (output start, offset, old_lane, new_lane,
                    input  plot, x, y, colour, busy, done);
    modport slave  (input  start, offset, old_lane, new_lane,
                    output plot, x, y, colour, busy, done);
endinterface

// File: rtl/lane_span_scheduler_span_walker.sv
// Walks one horizontal span: loads a start x and valid flag, then steps
// x once per cycle for LANE_W pixels, flagging the final pixel with last.
module span_walker #(
    parameter int LANE_W = tiles_pkg::LANE_W,
    parameter int X_W    = tiles_pkg::X_W
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           load,
    input  logic [X_W-1:0] load_x,
    input  logic           load_vld,
    output logic [X_W-1:0] x,
    output logic           vld,
    output logic           last
);
    localparam int CNT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

    logic [X_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;

    assign last = vld_q && (cnt_q == CNT_W'(LANE_W - 1));

    always_comb begin
        x_d   = x_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        if (load) begin
            vld_d = load_vld;
            cnt_d = '0;
            // Empty spans keep the previous x so no out-of-lane value appears.
            if (load_vld) x_d = load_x;
        end else if (vld_q) begin
            if (last) begin
                vld_d = 1'b0;
            end else begin
                x_d   = x_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_q   <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign x   = x_q;
    assign vld = vld_q;
endmodule

// File: rtl/lane_span_scheduler.sv
// Frame scheduler: per row, erase the old lane span then draw the new one.
// SPAN_SKIP_UNCHANGED_EN: rows with identical old/new codes emit no pixels.
module lane_span_scheduler #(
    parameter int NUM_ROWS  = tiles_pkg::NUM_ROWS,
    parameter int NUM_LANES = tiles_pkg::NUM_LANES,
    parameter int LANE_W    = tiles_pkg::LANE_W,
    parameter int LANE_X0   = tiles_pkg::LANE_X0,
    parameter int ROW_H     = tiles_pkg::ROW_H,
    parameter int X_W       = tiles_pkg::X_W,
    parameter int Y_W       = tiles_pkg::Y_W,
    parameter int OFS_W     = tiles_pkg::OFS_W,
    parameter int CODE_W    = tiles_pkg::CODE_W
) (
    input  logic                  clock,
    input  logic                  resetn,
    lane_span_scheduler_if.slave  bus
);
    import tiles_pkg::*;

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
`ifdef SPAN_SKIP_UNCHANGED_EN
    localparam bit SKIP_SAME = 1'b1;
`else
    localparam bit SKIP_SAME = 1'b0;
`endif

    function automatic logic code_ok(input logic [CODE_W-1:0] c);
        return (c != LANE_NONE) && (int'(c) <= NUM_LANES);
    endfunction

    function automatic logic [X_W-1:0] lane_x(input logic [CODE_W-1:0] c);
        int t;
        t = LANE_X0 + (int'(c) - 1) * LANE_W;
        return t[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] row_y(input logic [ROW_W-1:0] r, input logic [OFS_W-1:0] o);
        int t;
        t = int'(r) * ROW_H + int'(o);
        return t[Y_W-1:0];
    endfunction

    logic [1:0]                 state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d, row_nx;
    logic [OFS_W-1:0]           ofs_q, ofs_d;
    logic [NUM_ROWS*CODE_W-1:0] old_q, old_d, new_q, new_d;
    logic [Y_W-1:0]             y_q, y_d;
    logic [2:0]                 colour_q, colour_d;
    logic                       ld, ld_same, ld_vld, phase_end;
    logic [CODE_W-1:0]          ld_code;
    logic [X_W-1:0]             w_x;
    logic                       w_vld, w_last;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        ofs_d     = ofs_q;
        old_d     = old_q;
        new_d     = new_q;
        y_d       = y_q;
        colour_d  = colour_q;
        ld        = 1'b0;
        ld_code   = LANE_NONE;
        ld_same   = 1'b0;
        row_nx    = row_q + 1'b1;
        phase_end = !w_vld || w_last;
        case (state_q)
            IDLE: if (bus.start) begin
                // First beat is built straight from the inputs so it lands one cycle after start.
                ofs_d    = bus.offset;
                old_d    = bus.old_lane;
                new_d    = bus.new_lane;
                state_d  = ERASE;
                row_d    = '0;
                ld       = 1'b1;
                ld_code  = bus.old_lane[CODE_W-1:0];
                ld_same  = bus.old_lane[CODE_W-1:0] == bus.new_lane[CODE_W-1:0];
                y_d      = row_y('0, bus.offset);
                colour_d = COLOUR_WHITE;
            end
            ERASE: if (phase_end) begin
                state_d  = DRAW;
                ld       = 1'b1;
                ld_code  = new_q[row_q*CODE_W +: CODE_W];
                ld_same  = old_q[row_q*CODE_W +: CODE_W] == new_q[row_q*CODE_W +: CODE_W];
                colour_d = COLOUR_BLACK;
            end
            DRAW: if (phase_end) begin
                ld = 1'b1;
                if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d  = ERASE;
                    row_d    = row_nx;
                    ld_code  = old_q[row_nx*CODE_W +: CODE_W];
                    ld_same  = old_q[row_nx*CODE_W +: CODE_W] == new_q[row_nx*CODE_W +: CODE_W];
                    y_d      = row_y(row_nx, ofs_q);
                    colour_d = COLOUR_WHITE;
                end
            end
            default: state_d = IDLE;
        endcase
        ld_vld = code_ok(ld_code) && !(SKIP_SAME && ld_same);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            row_q    <= '0;
            ofs_q    <= '0;
            old_q    <= '0;
            new_q    <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            ofs_q    <= ofs_d;
            old_q    <= old_d;
            new_q    <= new_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    span_walker #(.LANE_W(LANE_W), .X_W(X_W)) u_walker (
        .clock    (clock),
        .resetn   (resetn),
        .load     (ld),
        .load_x   (lane_x(ld_code)),
        .load_vld (ld_vld),
        .x        (w_x),
        .vld      (w_vld),
        .last     (w_last)
    );

    assign bus.plot   = w_vld;
    assign bus.x      = w_x;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.busy   = (state_q == ERASE) || (state_q == DRAW);
    assign bus.done   = (state_q == DONE);
endmodule

// File: tb/tb_lane_span_scheduler.sv
// Scoreboard bench for lane_span_scheduler: expected pixels queued per frame,
// a negedge monitor pops and compares every plotted beat.
module tb_lane_span_scheduler;
    import tiles_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    lane_span_scheduler_if bus();
    lane_span_scheduler dut (.clock(clock), .resetn(resetn), .bus(bus));

`ifdef SPAN_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [2:0]     colour;
    } beat_t;

    typedef logic [NUM_ROWS*CODE_W-1:0] codes_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code_of(input codes_t v, input int r);
        return int'(v[r*CODE_W +: CODE_W]);
    endfunction

    function automatic int phase_len(input int c, input bit same);
        return (c >= 1 && c <= NUM_LANES && !(SKIP && same)) ? LANE_W : 1;
    endfunction

    // Reference model: queue every expected pixel, return cycles from start edge to done.
    task automatic expect_frame(input logic [OFS_W-1:0] ofs, input codes_t old, input codes_t nw, output int len);
        beat_t b;
        int c, yv;
        bit same;
        len = 1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            yv   = (r * ROW_H + int'(ofs)) % 256;
            same = code_of(old, r) == code_of(nw, r);
            for (int ph = 0; ph < 2; ph++) begin
                c = (ph == 0) ? code_of(old, r) : code_of(nw, r);
                len += phase_len(c, same);
                if (phase_len(c, same) == LANE_W)
                    for (int i = 0; i < LANE_W; i++) begin
                        b.x      = X_W'(LANE_X0 + (c - 1) * LANE_W + i);
                        b.y      = Y_W'(yv);
                        b.colour = (ph == 0) ? 3'b111 : 3'b000;
                        exp_q.push_back(b);
                    end
            end
        end
    endtask

    always @(negedge clock) begin : monitor
        beat_t e;
        if (mon_en && bus.plot) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_plot", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_x", int'(bus.x), int'(e.x));
                chk("beat_y", int'(bus.y), int'(e.y));
                chk("beat_colour", int'(bus.colour), int'(e.colour));
            end
        end
    end

    task automatic run_frame(input logic [OFS_W-1:0] ofs, input codes_t old, input codes_t nw,
                             input int probe_n, input bit probe_plot, input int probe_x, input int probe_y,
                             input int repulse_at, input int reset_at, input bit start_at_done);
        int len, n;
        bit seen;
        expect_frame(ofs, old, nw, len);
        mon_en       = 1'b1;
        bus.offset   = ofs;
        bus.old_lane = old;
        bus.new_lane = nw;
        bus.start    = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        n = 1;
        chk("busy_first", int'(bus.busy), 1);
        while (n <= 2000) begin
            if (n == probe_n) begin
                chk("probe_plot", int'(bus.plot), int'(probe_plot));
                if (probe_plot) chk("probe_x", int'(bus.x), probe_x);
                chk("probe_y", int'(bus.y), probe_y);
            end
            if (n == repulse_at) begin
                bus.start    = 1'b1;
                bus.offset   = ofs + 6'd9;
                bus.old_lane = ~old;
                bus.new_lane = ~nw;
            end
            if (n == repulse_at + 1) bus.start = 1'b0;
            if (n == reset_at) begin
                resetn = 1'b0;
                mon_en = 1'b0;
                @(posedge clock); #1;
                chk("rst_plot", int'(bus.plot), 0);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_done", int'(bus.done), 0);
                exp_q.delete();
                resetn = 1'b1;
                seen   = 1'b0;
                repeat (len) begin
                    @(posedge clock); #1;
                    if (bus.done || bus.busy) seen = 1'b1;
                end
                chk("no_done_after_reset", int'(seen), 0);
                return;
            end
            if (bus.done) break;
            @(posedge clock); #1;
            n++;
        end
        chk("frame_len", n, len);
        chk("queue_drained", exp_q.size(), 0);
        if (start_at_done) bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk("done_pulse_width", int'(bus.done), 0);
        chk("busy_after", int'(bus.busy), 0);
        if (start_at_done) begin
            @(posedge clock); #1;
            chk("start_in_done_busy", int'(bus.busy), 0);
            chk("start_in_done_plot", int'(bus.plot), 0);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.offset   = '0;
        bus.old_lane = '0;
        bus.new_lane = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_plot", int'(bus.plot), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_x", int'(bus.x), 0);
        chk("reset_y", int'(bus.y), 0);
        chk("reset_colour", int'(bus.colour), 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // All rows 1 -> 2; row 0 draw starts at cycle 21 with x=140, y=5.
        run_frame(6'd5, {6{3'd1}}, {6{3'd2}}, 21, 1'b1, 140, 5, 0, 0, 1'b1);
        // Mixed codes incl. empty and out-of-range; row 3 draw at cycle 65: x=180, y=125.
        run_frame(6'd5, {3'd2, 3'd4, 3'd0, 3'd0, 3'd5, 3'd1},
                        {3'd2, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2}, 65, 1'b1, 180, 125, 0, 0, 1'b0);
        // Start re-pulsed at cycle 50 with different inputs; row 1 erase at cycle 41: x=160, y=40.
        run_frame(6'd0, {6{3'd3}}, {6{3'd4}}, 41, 1'b1, 160, 40, 50, 0, 1'b0);
        // Reset at cycle 100 abandons the frame.
        run_frame(6'd10, {6{3'd2}}, {6{3'd1}}, 0, 1'b0, 0, 0, 0, 100, 1'b0);
        // Normal frame after reset; y wraps: row 5 at 200+63 -> 7, erase x=180 at cycle 201.
        run_frame(6'd63, {6{3'd4}}, {6{3'd1}}, 201, 1'b1, 180, 7, 0, 0, 1'b0);
`ifdef SPAN_SKIP_UNCHANGED_EN
        // Unchanged rows: no plots, done 13 cycles after start.
        run_frame(6'd0, {6{3'd3}}, {6{3'd3}}, 1, 1'b0, 0, 0, 0, 0, 1'b0);
`endif
        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
